// File: rtl/if_id_pipe_reg.sv
// DEPTH-stage IF/ID register chain with stall, flush and synchronous reset.
// Define IF_ID_PIPE_STATS_EN to add stall/flush/bubble event counters.
module if_id_pipe_reg #(
  parameter int                IW       = 32,
  parameter int                AW       = 32,
  parameter int                DEPTH    = 1,
  parameter logic [IW-1:0]     NOP_INST = '0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  input  logic [IW-1:0] in_inst,
  input  logic [AW-1:0] in_PCplus4,
  input  logic          stall,
  input  logic          flush,
  output logic          out_valid,
  output logic [IW-1:0] inst,
  output logic [AW-1:0] PCplus4
`ifdef IF_ID_PIPE_STATS_EN
  ,
  output logic [31:0]   stat_stall_cnt,
  output logic [31:0]   stat_flush_cnt,
  output logic [31:0]   stat_bubble_cnt
`endif
);

  logic          valid_q [DEPTH];
  logic          valid_d [DEPTH];
  logic [IW-1:0] inst_q  [DEPTH];
  logic [IW-1:0] inst_d  [DEPTH];
  logic [AW-1:0] pc_q    [DEPTH];
  logic [AW-1:0] pc_d    [DEPTH];

  // Invalid entries always carry bubble data, so the outputs need no masking.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k];
      inst_d[k]  = inst_q[k];
      pc_d[k]    = pc_q[k];
    end
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_d[k] = 1'b0;
        inst_d[k]  = NOP_INST;
        pc_d[k]    = '0;
      end
    end else if (!stall) begin
      valid_d[0] = in_valid;
      inst_d[0]  = in_valid ? in_inst : NOP_INST;
      pc_d[0]    = in_valid ? in_PCplus4 : '0;
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        inst_d[k]  = inst_q[k-1];
        pc_d[k]    = pc_q[k-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        inst_q[k]  <= NOP_INST;
        pc_q[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= valid_d[k];
        inst_q[k]  <= inst_d[k];
        pc_q[k]    <= pc_d[k];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign inst      = inst_q[DEPTH-1];
  assign PCplus4   = pc_q[DEPTH-1];

`ifdef IF_ID_PIPE_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // A stall under flush is not a hold, so it is not counted as a stall.
  always_comb begin
    stall_cnt_d  = stall_cnt_q  + {31'd0, (stall && !flush)};
    flush_cnt_d  = flush_cnt_q  + {31'd0, flush};
    bubble_cnt_d = bubble_cnt_q + {31'd0, !out_valid};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stat_stall_cnt  = stall_cnt_q;
  assign stat_flush_cnt  = flush_cnt_q;
  assign stat_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Scoreboard bench for if_id_pipe_reg: DEPTH 1, 2 and 3 instances share one
// stimulus; expected entries are queued at drive time and popped per cycle.
module tb_if_id_pipe_reg;

  typedef struct packed {
    logic        v;
    logic [31:0] i;
    logic [31:0] p;
  } exp_t;

  localparam exp_t BUB = '{v: 1'b0, i: 32'h0, p: 32'h0};

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_PCplus4;
  logic        stall;
  logic        flush;

  logic        v1, v2, v3;
  logic [31:0] i1, i2, i3;
  logic [31:0] p1, p2, p3;

  int n_cmp = 0;
  int n_err = 0;
  exp_t q[$];
  exp_t e;
  exp_t a;

`ifdef IF_ID_PIPE_STATS_EN
  logic [31:0] ss1, sf1, sb1, ss2, sf2, sb2, ss3, sf3, sb3;
`endif

  always #5 CLK = ~CLK;

  if_id_pipe_reg #(.IW(32), .AW(32), .DEPTH(1), .NOP_INST(32'h0)) d1 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_inst(in_inst),
    .in_PCplus4(in_PCplus4), .stall(stall), .flush(flush),
    .out_valid(v1), .inst(i1), .PCplus4(p1)
`ifdef IF_ID_PIPE_STATS_EN
    , .stat_stall_cnt(ss1), .stat_flush_cnt(sf1), .stat_bubble_cnt(sb1)
`endif
  );

  if_id_pipe_reg #(.IW(32), .AW(32), .DEPTH(2), .NOP_INST(32'h0)) d2 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_inst(in_inst),
    .in_PCplus4(in_PCplus4), .stall(stall), .flush(flush),
    .out_valid(v2), .inst(i2), .PCplus4(p2)
`ifdef IF_ID_PIPE_STATS_EN
    , .stat_stall_cnt(ss2), .stat_flush_cnt(sf2), .stat_bubble_cnt(sb2)
`endif
  );

  if_id_pipe_reg #(.IW(32), .AW(32), .DEPTH(3), .NOP_INST(32'h0)) d3 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_inst(in_inst),
    .in_PCplus4(in_PCplus4), .stall(stall), .flush(flush),
    .out_valid(v3), .inst(i3), .PCplus4(p3)
`ifdef IF_ID_PIPE_STATS_EN
    , .stat_stall_cnt(ss3), .stat_flush_cnt(sf3), .stat_bubble_cnt(sb3)
`endif
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    in_valid   = v;
    in_inst    = ins;
    in_PCplus4 = pc;
  endtask

  task automatic do_reset();
    RST = 1'b1; stall = 1'b0; flush = 1'b0;
    set_in(1'b0, 32'h0, 32'h0);
    tick();
    RST = 1'b0;
  endtask

  function automatic exp_t mk(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    exp_t r;
    r = v ? '{v: 1'b1, i: ins, p: pc} : BUB;
    return r;
  endfunction

  task automatic test_reset();
    stall = 1'b0; flush = 1'b0;
    RST = 1'b1;
    set_in(1'b1, 32'h1234_5678, 32'h44);
    for (int c = 0; c < 2; c++) begin
      tick();
      a = {v1, i1, p1};
      n_cmp++;
      if (a !== BUB) begin
        n_err++;
        $display("FAIL reset_d1[%0d] got %h want %h", c, a, BUB);
      end
      a = {v3, i3, p3};
      n_cmp++;
      if (a !== BUB) begin
        n_err++;
        $display("FAIL reset_d3[%0d] got %h want %h", c, a, BUB);
      end
    end
    RST = 1'b0;
  endtask

  task automatic test_stream();
    exp_t st [5];
    st[0] = mk(1'b1, 32'hA0, 32'd4);
    st[1] = mk(1'b1, 32'hA1, 32'd8);
    st[2] = mk(1'b1, 32'hA2, 32'd12);
    st[3] = mk(1'b0, 32'h0, 32'h0);
    st[4] = mk(1'b0, 32'h0, 32'h0);
    do_reset();
    q.delete();
    q.push_back(BUB);
    for (int c = 0; c < 5; c++) begin
      set_in(st[c].v, st[c].i, st[c].p);
      q.push_back(st[c]);
      tick();
      e = q.pop_front();
      a = {v2, i2, p2};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL stream[%0d] got %h want %h", c, a, e);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    set_in(1'b1, 32'hB0, 32'd16);
    tick();
    e = mk(1'b1, 32'hB0, 32'd16);
    a = {v1, i1, p1};
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL stall_load got %h want %h", a, e);
    end
    stall = 1'b1;
    set_in(1'b1, 32'hB1, 32'd20);
    for (int c = 0; c < 3; c++) begin
      tick();
      a = {v1, i1, p1};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL stall_hold[%0d] got %h want %h", c, a, e);
      end
    end
    stall = 1'b0;
    tick();
    e = mk(1'b1, 32'hB1, 32'd20);
    a = {v1, i1, p1};
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL stall_release got %h want %h", a, e);
    end
  endtask

  task automatic test_flush_over_stall();
    do_reset();
    q.delete();
    q.push_back(BUB);
    q.push_back(BUB);
    for (int c = 0; c < 3; c++) begin
      set_in(1'b1, 32'hC0 + c, 32'd40 + 32'(4 * c));
      q.push_back(mk(1'b1, 32'hC0 + c, 32'd40 + 32'(4 * c)));
      tick();
      e = q.pop_front();
      a = {v3, i3, p3};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL flush_fill[%0d] got %h want %h", c, a, e);
      end
    end
    flush = 1'b1; stall = 1'b1;
    set_in(1'b1, 32'hC3, 32'd52);
    tick();
    flush = 1'b0; stall = 1'b0;
    q.delete();
    q.push_back(BUB);
    q.push_back(BUB);
    a = {v3, i3, p3};
    n_cmp++;
    if (a !== BUB) begin
      n_err++;
      $display("FAIL flush_edge got %h want %h", a, BUB);
    end
    for (int c = 0; c < 4; c++) begin
      set_in(1'b1, 32'hC4 + c, 32'd56 + 32'(4 * c));
      q.push_back(mk(1'b1, 32'hC4 + c, 32'd56 + 32'(4 * c)));
      tick();
      e = q.pop_front();
      a = {v3, i3, p3};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL flush_after[%0d] got %h want %h", c, a, e);
      end
    end
  endtask

  task automatic test_bubble();
    do_reset();
    set_in(1'b1, 32'hD0, 32'd8);
    tick();
    set_in(1'b0, 32'hDEAD_BEEF, 32'h40);
    tick();
    a = {v1, i1, p1};
    n_cmp++;
    if (a !== BUB) begin
      n_err++;
      $display("FAIL bubble_norm got %h want %h", a, BUB);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      set_in(1'b1, 32'hE0 + c, 32'd100 + 32'(4 * c));
      tick();
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    a = {v2, i2, p2};
    n_cmp++;
    if (a !== BUB) begin
      n_err++;
      $display("FAIL midreset_d2 got %h want %h", a, BUB);
    end
    set_in(1'b0, 32'h0, 32'h0);
    tick();
    a = {v2, i2, p2};
    n_cmp++;
    if (a !== BUB) begin
      n_err++;
      $display("FAIL midreset_d2_drain got %h want %h", a, BUB);
    end
  endtask

  task automatic test_back_to_back();
    exp_t last;
    exp_t x;
    logic s;
    do_reset();
    q.delete();
    q.push_back(BUB);
    q.push_back(BUB);
    last = BUB;
    for (int c = 0; c < 40; c++) begin
      s = ($urandom_range(0, 3) == 0);
      x = mk(($urandom_range(0, 3) != 0), $urandom, $urandom);
      stall = s;
      set_in(x.v, $urandom, $urandom);
      if (x.v) set_in(1'b1, x.i, x.p);
      if (!s) begin
        q.push_back(x);
        last = q.pop_front();
      end
      tick();
      a = {v3, i3, p3};
      n_cmp++;
      if (a !== last) begin
        n_err++;
        $display("FAIL b2b[%0d] got %h want %h", c, a, last);
      end
    end
    stall = 1'b0;
  endtask

`ifdef IF_ID_PIPE_STATS_EN
  task automatic test_stats();
    do_reset();
    n_cmp++;
    if ({ss1, sf1, sb1} !== 96'h0) begin
      n_err++;
      $display("FAIL stats_reset got %h/%h/%h want 0/0/0", ss1, sf1, sb1);
    end
    set_in(1'b1, 32'hF0, 32'd4);
    stall = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    flush = 1'b1;
    tick();
    stall = 1'b0;
    tick();
    flush = 1'b0;
    n_cmp++;
    if (ss1 !== 32'd5) begin
      n_err++;
      $display("FAIL stats_stall got %0d want 5", ss1);
    end
    n_cmp++;
    if (sf1 !== 32'd2) begin
      n_err++;
      $display("FAIL stats_flush got %0d want 2", sf1);
    end
    n_cmp++;
    if (sb1 !== 32'd7) begin
      n_err++;
      $display("FAIL stats_bubble got %0d want 7", sb1);
    end
    n_cmp++;
    if (ss3 !== 32'd5 || sf3 !== 32'd2) begin
      n_err++;
      $display("FAIL stats_d3 got %0d/%0d want 5/2", ss3, sf3);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    n_cmp++;
    if ({ss1, sf1, sb1} !== 96'h0) begin
      n_err++;
      $display("FAIL stats_clear got %h/%h/%h want 0/0/0", ss1, sf1, sb1);
    end
  endtask
`endif

  initial begin
    RST = 1'b1; stall = 1'b0; flush = 1'b0;
    set_in(1'b0, 32'h0, 32'h0);
    test_reset();
    test_stream();
    test_stall();
    test_flush_over_stall();
    test_bubble();
    test_reset_midstream();
    test_back_to_back();
`ifdef IF_ID_PIPE_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
